// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector for the serial adder/subtractor result stream.
// Rebuilds LSB-first words and offers them on a one-deep valid/ready output buffer.
module serial_word_collector #(
   parameter int BIT_WIDTH = 8,
   parameter int CNT_W     = $clog2(BIT_WIDTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   input  logic                 start,
   input  logic                 carry_in,
   output logic [BIT_WIDTH-1:0] out_data,
   output logic                 out_carry,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [CNT_W-1:0]     bit_count,
   output logic                 frame_abort,
   output logic                 overrun,
   input  logic                 clear_overrun
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t                 state_q, state_d;
   logic [BIT_WIDTH-2:0]   shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0]   data_q, data_d;
   logic                   carry_q, carry_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;
   logic                   abort_q, abort_d;
   logic                   overrun_q, overrun_d;

   logic [BIT_WIDTH-1:0]   full_word;
   logic                   word_done;
   logic                   drop_word;
   logic                   drain;

   // Only BIT_WIDTH-1 bits need storing: the final bit arrives live with the last beat.
   assign full_word = {bit_in, shift_q};
   assign drain     = valid_q && out_ready;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      abort_d   = 1'b0;
      word_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (bit_valid && start) begin
               shift_d = full_word[BIT_WIDTH-1:1];
               cnt_d   = ONE;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (bit_valid) begin
               shift_d = full_word[BIT_WIDTH-1:1];
               if (start) begin
                  // Restart wins even on the last bit position; the partial word is discarded.
                  abort_d = 1'b1;
                  cnt_d   = ONE;
               end else if (cnt_q == LAST_IDX) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == COLLECT);
   end

   always_comb begin
      data_d    = data_q;
      carry_d   = carry_q;
      valid_d   = valid_q;
      drop_word = 1'b0;

      if (word_done) begin
         // A buffer being drained this cycle can take the new word on the same edge.
         if (!valid_q || out_ready) begin
            data_d  = full_word;
            carry_d = carry_in;
            valid_d = 1'b1;
         end else begin
            drop_word = 1'b1;
         end
      end else if (drain) begin
         valid_d = 1'b0;
      end

      // A new drop in the same cycle as a clear keeps the flag set.
      overrun_d = drop_word || (overrun_q && !clear_overrun);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         carry_q   <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         abort_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         carry_q   <= carry_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         abort_q   <= abort_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_data    = data_q;
   assign out_carry   = carry_q;
   assign out_valid   = valid_q;
   assign busy        = busy_q;
   assign bit_count   = cnt_q;
   assign frame_abort = abort_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Scenario bench for serial_word_collector: expected {carry,data} words are queued as frames are sent.
module tb_serial_word_collector;

   localparam int BW    = 8;
   localparam int CW    = $clog2(BW + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          bit_in = 1'b0;
   logic          bit_valid = 1'b0;
   logic          start = 1'b0;
   logic          carry_in = 1'b0;
   logic [BW-1:0] out_data;
   logic          out_carry;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic [CW-1:0] bit_count;
   logic          frame_abort;
   logic          overrun;
   logic          clear_overrun = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   logic [BW:0] exp_q[$];
   logic [BW:0] exp;

   serial_word_collector #(.BIT_WIDTH(BW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
      .start(start), .carry_in(carry_in), .out_data(out_data), .out_carry(out_carry),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .bit_count(bit_count),
      .frame_abort(frame_abort), .overrun(overrun), .clear_overrun(clear_overrun)
   );

   always #5 clock = ~clock;

   // Called 1 time unit after a rising edge; returns 1 time unit after the sampling edge.
   task automatic send_bit(input logic b, input logic st, input logic c);
      bit_in = b; bit_valid = 1'b1; start = st; carry_in = c;
      @(posedge clock); #1;
      bit_valid = 1'b0; start = 1'b0; carry_in = 1'b0; bit_in = 1'b0;
   endtask

   task automatic send_bits(input logic [BW-1:0] w, input logic c, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         send_bit(w[i], (i == 0), (i == BW - 1) ? c : 1'b0);
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
      n_checks++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", out_carry); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (bit_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bit_count); end
      n_checks++; if ({frame_abort, overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {frame_abort, overrun}); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      exp_q.push_back({1'b1, 8'hA5});
      send_bits(8'hA5, 1'b1, 0, 0);
      n_checks++; if ({busy, bit_count} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL basic_first got busy=%b cnt=%0d want busy=1 cnt=1", busy, bit_count); end
      send_bits(8'hA5, 1'b1, 1, 6);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
      send_bits(8'hA5, 1'b1, 7, 7);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL basic_word got v=%b c=%b d=%h want v=1 c=%b d=%h", out_valid, out_carry, out_data, exp[BW], exp[BW-1:0]); end
      n_checks++; if ({busy, bit_count} !== 5'b0) begin n_fail++; $display("FAIL basic_done got busy=%b cnt=%0d want 0/0", busy, bit_count); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b want 0", out_valid); end
   endtask

   task automatic test_gapped();
      logic [BW-1:0] w;
      w = 8'h3C;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      n_checks++; if ({busy, bit_count} !== 5'b0) begin n_fail++; $display("FAIL gap_stray got busy=%b cnt=%0d want 0/0", busy, bit_count); end
      exp_q.push_back({1'b0, w});
      for (int i = 0; i < BW; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         send_bits(w, 1'b0, i, i);
         n_checks++; if (bit_count !== CW'((i + 1) % BW)) begin n_fail++; $display("FAIL gap_count got %0d want %0d", bit_count, (i + 1) % BW); end
      end
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL gap_word got v=%b c=%b d=%h want v=1 d=%h", out_valid, out_carry, out_data, exp[BW-1:0]); end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 8'h6B});
      exp_q.push_back({1'b1, 8'hC4});
      send_bits(8'h6B, 1'b0, 0, BW - 1);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL b2b_first got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[BW-1:0]); end
      send_bits(8'hC4, 1'b1, 0, 0);
      n_checks++; if ({out_valid, busy, bit_count} !== {1'b0, 1'b1, 4'd1}) begin n_fail++; $display("FAIL b2b_restart got v=%b busy=%b cnt=%0d want 0/1/1", out_valid, busy, bit_count); end
      send_bits(8'hC4, 1'b1, 1, BW - 1);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL b2b_second got v=%b c=%b d=%h want v=1 c=%b d=%h", out_valid, out_carry, out_data, exp[BW], exp[BW-1:0]); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 8'h11});
      send_bits(8'h11, 1'b0, 0, BW - 1);
      send_bits(8'h22, 1'b1, 0, BW - 1);
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, 1'b0, 8'h11}) begin n_fail++; $display("FAIL bp_hold got v=%b c=%b d=%h want v=1 c=0 d=11", out_valid, out_carry, out_data); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b want 1", overrun); end
      clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_clear got %b want 0", overrun); end
      out_ready = 1'b1;
      exp = exp_q.pop_front();
      n_checks++; if ({out_carry, out_data} !== exp) begin n_fail++; $display("FAIL bp_drain got d=%h want d=%h", out_data, exp[BW-1:0]); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
   endtask

   task automatic test_drain_load();
      out_ready = 1'b0;
      exp_q.push_back({1'b1, 8'h11});
      send_bits(8'h11, 1'b1, 0, BW - 1);
      send_bits(8'h22, 1'b0, 0, BW - 2);
      out_ready = 1'b1;
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL dl_buffered got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[BW-1:0]); end
      exp_q.push_back({1'b0, 8'h22});
      send_bits(8'h22, 1'b0, BW - 1, BW - 1);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL dl_load got v=%b c=%b d=%h want v=1 c=%b d=%h", out_valid, out_carry, out_data, exp[BW], exp[BW-1:0]); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL dl_overrun got %b want 0", overrun); end
      tick();
   endtask

   task automatic test_abort();
      out_ready = 1'b1;
      send_bits(8'hFF, 1'b1, 0, 4);
      n_checks++; if ({bit_count, frame_abort} !== {4'd5, 1'b0}) begin n_fail++; $display("FAIL ab_partial got cnt=%0d abort=%b want 5/0", bit_count, frame_abort); end
      exp_q.push_back({1'b0, 8'h5A});
      send_bits(8'h5A, 1'b0, 0, 0);
      n_checks++; if ({frame_abort, busy, bit_count} !== {1'b1, 1'b1, 4'd1}) begin n_fail++; $display("FAIL ab_restart got abort=%b busy=%b cnt=%0d want 1/1/1", frame_abort, busy, bit_count); end
      send_bits(8'h5A, 1'b0, 1, 1);
      n_checks++; if ({frame_abort, bit_count} !== {1'b0, 4'd2}) begin n_fail++; $display("FAIL ab_pulse got abort=%b cnt=%0d want 0/2", frame_abort, bit_count); end
      send_bits(8'h5A, 1'b0, 2, BW - 1);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL ab_word got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[BW-1:0]); end
      tick();
      send_bits(8'h0F, 1'b1, 0, BW - 2);
      exp_q.push_back({1'b1, 8'h96});
      send_bits(8'h96, 1'b1, 0, 0);
      n_checks++; if ({frame_abort, out_valid, bit_count} !== {1'b1, 1'b0, 4'd1}) begin n_fail++; $display("FAIL ab_last_pos got abort=%b v=%b cnt=%0d want 1/0/1", frame_abort, out_valid, bit_count); end
      send_bits(8'h96, 1'b1, 1, BW - 1);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL ab_last_word got v=%b c=%b d=%h want v=1 c=%b d=%h", out_valid, out_carry, out_data, exp[BW], exp[BW-1:0]); end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send_bits(8'h77, 1'b1, 0, BW - 1);
      send_bits(8'h33, 1'b0, 0, 2);
      n_checks++; if ({out_valid, out_data, bit_count} !== {1'b1, 8'h77, 4'd3}) begin n_fail++; $display("FAIL rm_before got v=%b d=%h cnt=%0d want 1/77/3", out_valid, out_data, bit_count); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({out_valid, out_carry, out_data} !== 10'b0) begin n_fail++; $display("FAIL rm_async_out got v=%b c=%b d=%h want 0/0/00", out_valid, out_carry, out_data); end
      n_checks++; if ({busy, bit_count, frame_abort, overrun} !== 7'b0) begin n_fail++; $display("FAIL rm_async_ctl got busy=%b cnt=%0d abort=%b ovr=%b want all 0", busy, bit_count, frame_abort, overrun); end
      #2 reset = 1'b0;
      tick();
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 8'h81});
      send_bits(8'h81, 1'b0, 0, BW - 1);
      exp = exp_q.pop_front();
      n_checks++; if ({out_valid, out_carry, out_data} !== {1'b1, exp}) begin n_fail++; $display("FAIL rm_fresh got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[BW-1:0]); end
      tick();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d entries want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_back_to_back();
      test_backpressure();
      test_drain_load();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
